// File: rtl/pll_dyn_ctrl_if.sv
// Reconfiguration request port: level request with held fields, one-cycle ack.
interface pll_dyn_ctrl_if;
  logic       req;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [5:0] odsel;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic       ack;

  modport master (
    output req, idsel, fbdsel, odsel, psda, dutyda,
    input  ack
  );

  modport slave (
    input  req, idsel, fbdsel, odsel, psda, dutyda,
    output ack
  );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// PLL bring-up / reconfiguration sequencer: reset hold, lock wait with retry,
// lock qualification, lock-loss recovery and a req/ack port for new settings.
module pll_dyn_ctrl #(
  parameter int         RST_HOLD     = 16,
  parameter int         LOCK_TIMEOUT = 4800,
  parameter int         LOCK_STABLE  = 64,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] DEF_IDSEL    = 6'd0,
  parameter logic [5:0] DEF_FBDSEL   = 6'd0,
  parameter logic [5:0] DEF_ODSEL    = 6'd0,
  parameter logic [3:0] DEF_PSDA     = 4'd0,
  parameter logic [3:0] DEF_DUTYDA   = 4'd8
) (
  input  logic             clk,
  input  logic             rst,
  pll_dyn_ctrl_if.slave    cfg,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic [5:0]       pll_idsel,
  output logic [5:0]       pll_fbdsel,
  output logic [5:0]       pll_odsel,
  output logic [3:0]       pll_psda,
  output logic [3:0]       pll_dutyda,
  output logic             ready,
  output logic             busy,
  output logic             fail,
  output logic             lock_lost,
  output logic [1:0]       retry_cnt
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [15:0] RST_LAST     = 16'(RST_HOLD - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_CNT   = 16'(LOCK_STABLE);
  localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  retry_reg, retry_next;
  logic        lost_reg, lost_next;
  logic        ack_reg, ack_next;
  logic [5:0]  idsel_reg, idsel_next;
  logic [5:0]  fbdsel_reg, fbdsel_next;
  logic [5:0]  odsel_reg, odsel_next;
  logic [3:0]  psda_reg, psda_next;
  logic [3:0]  dutyda_reg, dutyda_next;
  logic        lock_meta_reg, lock_s_reg;
  logic        accept;
  logic [2:0]  retry_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RST;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      lost_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      idsel_reg     <= DEF_IDSEL;
      fbdsel_reg    <= DEF_FBDSEL;
      odsel_reg     <= DEF_ODSEL;
      psda_reg      <= DEF_PSDA;
      dutyda_reg    <= DEF_DUTYDA;
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      lost_reg      <= lost_next;
      ack_reg       <= ack_next;
      idsel_reg     <= idsel_next;
      fbdsel_reg    <= fbdsel_next;
      odsel_reg     <= odsel_next;
      psda_reg      <= psda_next;
      dutyda_reg    <= dutyda_next;
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  assign accept    = cfg.req && ((state_reg == S_RUN) || (state_reg == S_FAIL));
  assign retry_inc = {1'b0, retry_reg} + 3'd1;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    retry_next  = retry_reg;
    lost_next   = lost_reg;
    ack_next    = 1'b0;
    idsel_next  = idsel_reg;
    fbdsel_next = fbdsel_reg;
    odsel_next  = odsel_reg;
    psda_next   = psda_reg;
    dutyda_next = dutyda_reg;

    case (state_reg)
      S_RST: begin
        if (cnt_reg == RST_LAST) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_WAIT: begin
        if (lock_s_reg) begin
          state_next = S_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry_next = retry_inc[1:0];
          cnt_next   = '0;
          state_next = (retry_inc < RETRY_LIMIT) ? S_RST : S_FAIL;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_STABLE: begin
        // A single low sample restarts qualification without costing a retry.
        if (!lock_s_reg) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else if ((cnt_reg + 16'd1) == STABLE_CNT) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_RUN: begin
        if (!lock_s_reg) begin
          state_next = S_RST;
          cnt_next   = '0;
          retry_next = '0;
          lost_next  = 1'b1;
        end
      end
      S_FAIL: begin
        state_next = S_FAIL;
      end
      default: begin
        state_next = S_RST;
        cnt_next   = '0;
      end
    endcase

    // An accepted request overrides a simultaneous lock drop in RUN.
    if (accept) begin
      state_next  = S_RST;
      cnt_next    = '0;
      retry_next  = '0;
      lost_next   = 1'b0;
      ack_next    = 1'b1;
      idsel_next  = cfg.idsel;
      fbdsel_next = cfg.fbdsel;
      odsel_next  = cfg.odsel;
      psda_next   = cfg.psda;
      dutyda_next = cfg.dutyda;
    end
  end

  assign cfg.ack    = ack_reg;
  assign pll_rst    = (state_reg == S_RST) || (state_reg == S_FAIL);
  assign ready      = (state_reg == S_RUN);
  assign busy       = (state_reg == S_RST) || (state_reg == S_WAIT) || (state_reg == S_STABLE);
  assign fail       = (state_reg == S_FAIL);
  assign lock_lost  = lost_reg;
  assign retry_cnt  = retry_reg;
  assign pll_idsel  = idsel_reg;
  assign pll_fbdsel = fbdsel_reg;
  assign pll_odsel  = odsel_reg;
  assign pll_psda   = psda_reg;
  assign pll_dutyda = dutyda_reg;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked against a phase model.
module tb_pll_dyn_ctrl;
  localparam int         P_RST_HOLD = 4;
  localparam int         P_TIMEOUT  = 20;
  localparam int         P_STABLE   = 5;
  localparam int         P_RETRY    = 2;
  localparam logic [5:0] D_ID = 6'd2;
  localparam logic [5:0] D_FB = 6'd4;
  localparam logic [5:0] D_OD = 6'd6;
  localparam logic [3:0] D_PS = 4'd1;
  localparam logic [3:0] D_DU = 4'd8;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;

  logic clk = 1'b0;
  logic rst;
  logic pll_lock;
  logic pll_rst, ready, busy, fail, lock_lost;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [3:0] pll_psda, pll_dutyda;
  logic [1:0] retry_cnt;

  pll_dyn_ctrl_if cfg_bus ();

  pll_dyn_ctrl #(
    .RST_HOLD(P_RST_HOLD), .LOCK_TIMEOUT(P_TIMEOUT), .LOCK_STABLE(P_STABLE),
    .MAX_RETRY(P_RETRY), .DEF_IDSEL(D_ID), .DEF_FBDSEL(D_FB), .DEF_ODSEL(D_OD),
    .DEF_PSDA(D_PS), .DEF_DUTYDA(D_DU)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg_bus.slave), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_odsel(pll_odsel), .pll_psda(pll_psda), .pll_dutyda(pll_dutyda),
    .ready(ready), .busy(busy), .fail(fail), .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: which phase the sequencer is in and how long it has been there.
  typedef struct {
    int         phase;
    int         elapsed;
    int         retry;
    bit         lost;
    bit         ack;
    logic [5:0] id, fb, od;
    logic [3:0] ps, du;
    bit         h1, h2;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, bit r, bit lk, bit rq,
                                  logic [5:0] i, logic [5:0] f, logic [5:0] o,
                                  logic [3:0] p, logic [3:0] d);
    model_t n = c;
    bit ls;
    if (r) begin
      n.phase = PH_RST; n.elapsed = 0; n.retry = 0; n.lost = 0; n.ack = 0;
      n.id = D_ID; n.fb = D_FB; n.od = D_OD; n.ps = D_PS; n.du = D_DU;
      n.h1 = 0; n.h2 = 0;
      return n;
    end
    ls = c.h2;
    n.h2 = c.h1;
    n.h1 = lk;
    n.ack = 0;
    if (rq && (c.phase == PH_RUN || c.phase == PH_FAIL)) begin
      n.phase = PH_RST; n.elapsed = 0; n.retry = 0; n.lost = 0; n.ack = 1;
      n.id = i; n.fb = f; n.od = o; n.ps = p; n.du = d;
      return n;
    end
    case (c.phase)
      PH_RST: begin
        n.elapsed = c.elapsed + 1;
        if (n.elapsed == P_RST_HOLD) begin n.phase = PH_WAIT; n.elapsed = 0; end
      end
      PH_WAIT: begin
        if (ls) begin
          n.phase = PH_STABLE; n.elapsed = 0;
        end else begin
          n.elapsed = c.elapsed + 1;
          if (n.elapsed == P_TIMEOUT) begin
            n.retry = c.retry + 1;
            n.elapsed = 0;
            n.phase = (n.retry < P_RETRY) ? PH_RST : PH_FAIL;
          end
        end
      end
      PH_STABLE: begin
        if (!ls) begin
          n.phase = PH_WAIT; n.elapsed = 0;
        end else begin
          n.elapsed = c.elapsed + 1;
          if (n.elapsed == P_STABLE) begin n.phase = PH_RUN; n.elapsed = 0; end
        end
      end
      PH_RUN: begin
        if (!ls) begin n.phase = PH_RST; n.elapsed = 0; n.retry = 0; n.lost = 1; end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, rst, pll_lock, cfg_bus.req, cfg_bus.idsel, cfg_bus.fbdsel,
              cfg_bus.odsel, cfg_bus.psda, cfg_bus.dutyda);

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every DUT output against the model.
  task automatic tick();
    logic [7:0]  exp_st, act_st;
    logic [25:0] exp_sel, act_sel;
    @(negedge clk);
    if (chk_en) begin
      exp_st = {(m.phase == PH_RST || m.phase == PH_FAIL), (m.phase == PH_RUN),
                (m.phase == PH_RST || m.phase == PH_WAIT || m.phase == PH_STABLE),
                (m.phase == PH_FAIL), m.lost, 2'(m.retry), m.ack};
      act_st = {pll_rst, ready, busy, fail, lock_lost, retry_cnt, cfg_bus.ack};
      exp_sel = {m.id, m.fb, m.od, m.ps, m.du};
      act_sel = {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda};
      checks++;
      if (act_st !== exp_st) begin
        errors++;
        $display("FAIL model_status t=%0t got rst/rdy/busy/fail/lost/retry/ack=%b expected %b",
                 $time, act_st, exp_st);
      end
      checks++;
      if (act_sel !== exp_sel) begin
        errors++;
        $display("FAIL model_selects t=%0t got %h expected %h", $time, act_sel, exp_sel);
      end
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return ready;
      1: return pll_rst;
      2: return fail;
      3: return cfg_bus.ack;
      default: return lock_lost;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input bit val, input int budget, input string name);
    int k = 0;
    while (sig(sel) != val && k < budget) begin tick(); k++; end
    checks++;
    if (sig(sel) != val) begin
      errors++;
      $display("FAIL timeout_%s: got no event within %0d cycles", name, budget);
    end
  endtask

  task automatic set_req(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o,
                         input logic [3:0] p, input logic [3:0] d);
    cfg_bus.req = 1'b1; cfg_bus.idsel = i; cfg_bus.fbdsel = f; cfg_bus.odsel = o;
    cfg_bus.psda = p; cfg_bus.dutyda = d;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_lost"}, lock_lost, 0);
    chk({tag, "_ack"}, cfg_bus.ack, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_idsel"}, pll_idsel, D_ID);
    chk({tag, "_dutyda"}, pll_dutyda, D_DU);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int k;
    int acks;
    int rq[$];
    logic [1:0] prev;
    rst = 1'b1; pll_lock = 1'b0;
    cfg_bus.req = 1'b0; cfg_bus.idsel = '0; cfg_bus.fbdsel = '0; cfg_bus.odsel = '0;
    cfg_bus.psda = '0; cfg_bus.dutyda = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    repeat (2) tick();
    chk_reset_values("reset");

    // Bring-up with default selects.
    rst = 1'b0;
    k = 0;
    while (pll_rst && k < 50) begin k++; tick(); end
    chk("rst_hold_cycles", k, 4);
    repeat (6) tick();
    pll_lock = 1'b1;
    k = 0;
    while (!ready && k < 100) begin tick(); k++; end
    chk("lock_to_ready", k, 8);
    chk("bringup_idsel", pll_idsel, D_ID);
    $display("bring-up: ready after %0d cycles, idsel=%0d", k, pll_idsel);

    // Reconfiguration from RUN.
    set_req(6'd3, 6'd5, 6'd8, 4'd7, 4'd3);
    k = 0;
    while (!cfg_bus.ack && k < 20) begin tick(); k++; end
    chk("accept_latency", k, 1);
    chk("ack_pll_rst", pll_rst, 1);
    chk("ack_idsel", pll_idsel, 3);
    chk("ack_fbdsel", pll_fbdsel, 5);
    chk("ack_odsel", pll_odsel, 8);
    chk("ack_ready", ready, 0);
    $display("reconfig: ack idsel=%0d fbdsel=%0d odsel=%0d", pll_idsel, pll_fbdsel, pll_odsel);
    cfg_bus.req = 1'b0;
    tick();
    chk("ack_single_pulse", cfg_bus.ack, 0);
    wait_sig(0, 1, 100, "relock");
    chk("relock_lost", lock_lost, 0);

    // One-cycle lock drop in RUN.
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_sig(4, 1, 20, "lock_lost");
    chk("lost_ready", ready, 0);
    chk("lost_idsel_kept", pll_idsel, 3);
    $display("lock loss: lost=%0d ready=%0d idsel=%0d", lock_lost, ready, pll_idsel);
    wait_sig(0, 1, 100, "recover");

    // Glitch during qualification.
    pll_lock = 1'b0;
    wait_sig(1, 1, 20, "glitch_rst");
    wait_sig(1, 0, 20, "glitch_wait");
    pll_lock = 1'b1;
    repeat (4) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    k = 0;
    while (!ready && k < 100) begin tick(); k++; end
    chk("glitch_requalify", k, 8);
    chk("glitch_retry", retry_cnt, 0);

    // No lock at all: retries exhausted.
    rst = 1'b1; pll_lock = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    k = 0; prev = 2'd0;
    while (!fail && k < 200) begin
      tick(); k++;
      if (retry_cnt != prev) begin rq.push_back(int'(retry_cnt)); prev = retry_cnt; end
    end
    chk("fail_cycles", k, 48);
    chk("retry_steps", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("retry_first", rq[0], 1);
      chk("retry_second", rq[1], 2);
    end
    repeat (5) tick();
    chk("fail_pll_rst", pll_rst, 1);
    chk("fail_busy", busy, 0);
    $display("fail: after %0d cycles retry=%0d", k, retry_cnt);

    // Accept from FAIL.
    set_req(6'd9, 6'd10, 6'd11, 4'd2, 4'd5);
    wait_sig(3, 1, 5, "fail_ack");
    chk("fail_cleared", fail, 0);
    chk("fail_retry_cleared", retry_cnt, 0);
    chk("fail_ack_idsel", pll_idsel, 9);
    cfg_bus.req = 1'b0;

    // Request during WAIT is held off until RUN.
    wait_sig(1, 0, 20, "wait_entry");
    set_req(6'd12, 6'd13, 6'd14, 4'd4, 4'd6);
    acks = 0;
    repeat (15) begin tick(); if (cfg_bus.ack) acks++; end
    chk("no_ack_in_wait", acks, 0);
    pll_lock = 1'b1;
    wait_sig(3, 1, 100, "run_ack");
    chk("run_ack_idsel", pll_idsel, 12);
    cfg_bus.req = 1'b0;
    acks = 0;
    repeat (4) begin tick(); if (cfg_bus.ack) acks++; end
    chk("one_ack_only", acks, 0);

    // Reset in the middle of qualification.
    wait_sig(1, 0, 20, "stable_entry");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_reset_values("mid_rst");
    rst = 1'b0;

    // Randomized traffic.
    pll_lock = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) begin rst = 1'b1; cfg_bus.req = 1'b0; end
      if (cfg_bus.req && cfg_bus.ack) begin
        $display("random: ack idsel=%0d fbdsel=%0d odsel=%0d", pll_idsel, pll_fbdsel, pll_odsel);
        cfg_bus.req = 1'b0;
      end else if (!cfg_bus.req && !rst && $urandom_range(0, 24) == 0) begin
        set_req(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 15) == 0) pll_lock = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
